mux_scan_sel: RTL and testbench
===============================

# mux_scan_sel

Registered, parametrised N-channel multiplexer. It is the clocked successor to our combinational 4:1 mux. Adds width and channel-count generics, a registered output, a manual-select mode and an automatic scan mode that dwells on each channel for a programmable number of cycles. It sits between parallel sample sources and a single downstream consumer.

## Interface
- `WIDTH`, 8, data bits per channel (≥1)
- `NCH`, 4, number of input channels (2..16, need not be a power of 2)
- `DWELL`, 4, cycles spent on each channel in scan mode (≥1)
- `clk`  in  1  rising-edge clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `din`  in  NCH*WIDTH  packed channel data; channel k = `din[k*WIDTH +: WIDTH]`
- `mode`  in  1  0 = manual (use `sel`), 1 = scan
- `sel`  in  SW = max(1,$clog2(NCH))  manual channel index
- `hold`  in  1  freeze all state and outputs
- `dout`  out  WIDTH  registered selected data
- `ch`  out  SW  index of the channel currently driving `dout`
- `valid`  out  1  `dout`/`ch` hold a legitimate capture
- `err`  out  1  last manual capture had `sel` ≥ NCH

## Operation
- Reset (rst=1 at a rising edge): `dout`=0, `ch`=0, `valid`=0, `err`=0, dwell counter=0, scan index=0. Reset overrides `hold` and `mode`.
- Manual mode (mode=0, hold=0), each edge:
  - sel<NCH: `dout`←din[sel], `ch`←sel, `valid`←1, `err`←0.
  - sel≥NCH: `dout`←0, `ch`←sel, `valid`←0, `err`←1.
  - The scan index tracks `sel`, wrapped to 0 when out of range. The dwell counter is held at 0.
- Scan mode (mode=1, hold=0), each edge:
  - `dout`←din[scan index], `ch`←scan index, `valid`←1, `err`←0.
  - When the dwell counter equals DWELL-1, the counter clears and the scan index advances. Otherwise the counter increments.
  - The scan index wraps from NCH-1 to 0.
- Mode change manual→scan: scanning starts at the channel last selected manually, with dwell=0.
- Mode change scan→manual: `sel` takes effect at the same edge.
- hold=1 (rst=0): every register keeps its value. `din` changes are not reflected. Releasing `hold` resumes from the exact dwell count.
- DWELL=1: the channel advances every cycle.

## Timing
- Latency is one cycle: inputs sampled at edge t appear on `dout`/`ch`/`valid`/`err` after edge t.
- Outputs are driven only by registers; there is no combinational path from input to output.
- Scan sequence for DWELL=D: each channel appears for exactly D consecutive edges, for a period of NCH·D cycles.
- Reset asserted mid-dwell: outputs and counters reach their reset values at that edge. With mode=1 held, the first post-reset capture is channel 0 with dwell=0.
- If rst and hold are asserted together, rst wins.

## Structure
- Package `mux_pkg`:
  - enum `mux_mode_t` {MODE_MANUAL, MODE_SCAN}
  - function `sel_w(n)` returning max(1,$clog2(n))
- Sub-module `dwell_counter`, parameter DWELL:
  - Ports: clk, rst, en, clr; output `wrap`, asserted when count = DWELL-1 and en=1.
  - Instantiated once to drive scan-index advance.
- Top level: input slicing, scan-index register, output registers.

## Test plan
- Reset: hold rst=1 for 2 cycles with random `din` → `dout`=0, `ch`=0, `valid`=0, `err`=0. First edge after release in manual mode, sel=2, din[2]=8'hA5 → `dout`=A5, `ch`=2, `valid`=1.
- Manual sweep, WIDTH=8, NCH=4: din = {8'h44,8'h33,8'h22,8'h11}, sel 0→3 → `dout` 11,22,33,44, each one cycle after its `sel`.
- Out-of-range select, NCH=5 (SW=3): sel=6 → `err`=1, `valid`=0, `dout`=0. Then sel=4 → `err`=0, `valid`=1, `dout`=din[4].
- Scan, NCH=4, DWELL=3: `ch` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0… Assert hold for 5 cycles after the second `ch`=1 → `ch` stays 1 throughout, then one more cycle of 1 before 2.
- Mode switch: manual sel=2 for 2 cycles, then mode=1 with DWELL=2 → `ch` 2,2,3,3,0,0.
- Reset mid-scan: rst=1 while `ch`=3 with dwell count 1, mode=1 held → reset values after the rst edge. The first three post-release captures with DWELL=3 are `ch`=0.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encoding and select-width helper for mux_scan_sel
package mux_pkg;
  typedef enum logic {MODE_MANUAL = 1'b0, MODE_SCAN = 1'b1} mux_mode_t;
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/dwell_counter.sv
// dwell_counter: counts scan dwell cycles and flags the last cycle on each channel
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign wrap = en && (cnt_q == CW'(DWELL - 1));
  // next count: clear in manual mode, hold when neither enabled nor cleared
  always_comb begin
    cnt_d = clr ? '0 : !en ? cnt_q : wrap ? '0 : cnt_q + CW'(1);
  end
  // count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered N-channel mux with manual select and timed scan mode
module mux_scan_sel
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int DWELL = 4,
  localparam int SW   = sel_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 mode,
  input  logic [SW-1:0]        sel,
  input  logic                 hold,
  output logic [WIDTH-1:0]     dout,
  output logic [SW-1:0]        ch,
  output logic                 valid,
  output logic                 err
);
  localparam logic [SW:0]   NCH_W = (SW + 1)'(NCH);
  localparam logic [SW-1:0] LAST  = SW'(NCH - 1);
  logic [WIDTH-1:0] chan [NCH];
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SW-1:0]    ch_q, ch_d, idx_q, idx_d;
  logic             valid_q, valid_d, err_q, err_d;
  logic             is_scan, in_rng, wrap;
  assign is_scan = (mode == MODE_SCAN);
  assign in_rng  = {1'b0, sel} < NCH_W;
  // slice the packed input bus into per-channel words
  always_comb begin
    for (int k = 0; k < NCH; k++) chan[k] = din[k*WIDTH +: WIDTH];
  end
  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .en   (!hold && is_scan),
    .clr  (!hold && !is_scan),
    .wrap (wrap)
  );
  // next-state: hold freezes everything, scan follows idx_q, manual follows sel
  always_comb begin
    dout_d  = hold ? dout_q  : is_scan ? chan[idx_q] : in_rng ? chan[sel] : '0;
    ch_d    = hold ? ch_q    : is_scan ? idx_q : sel;
    valid_d = hold ? valid_q : is_scan || in_rng;
    err_d   = hold ? err_q   : !is_scan && !in_rng;
    idx_d   = hold ? idx_q
            : !is_scan ? (in_rng ? sel : '0)
            : !wrap ? idx_q
            : (idx_q == LAST) ? '0 : idx_q + SW'(1);
  end
  // output and scan-index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end
  assign dout  = dout_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign err   = err_q;
endmodule

// File: tb/tb_mux_scan_sel.sv
// tb_mux_scan_sel: directed checks of manual, out-of-range, scan, hold, mode switch and reset
module tb_mux_scan_sel;
  logic        clk = 1'b0;
  logic        rst, mode, hold;
  logic [31:0] din_a;
  logic [39:0] din_b;
  logic [1:0]  sel_a;
  logic [2:0]  sel_b;
  logic [7:0]  dout_a, dout_b, dout_c;
  logic [1:0]  ch_a, ch_c;
  logic [2:0]  ch_b;
  logic        valid_a, valid_b, valid_c, err_a, err_b, err_c;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  mux_scan_sel #(.WIDTH(8), .NCH(4), .DWELL(3)) u_a (
    .clk(clk), .rst(rst), .din(din_a), .mode(mode), .sel(sel_a), .hold(hold),
    .dout(dout_a), .ch(ch_a), .valid(valid_a), .err(err_a));
  mux_scan_sel #(.WIDTH(8), .NCH(5), .DWELL(3)) u_b (
    .clk(clk), .rst(rst), .din(din_b), .mode(mode), .sel(sel_b), .hold(hold),
    .dout(dout_b), .ch(ch_b), .valid(valid_b), .err(err_b));
  mux_scan_sel #(.WIDTH(8), .NCH(4), .DWELL(2)) u_c (
    .clk(clk), .rst(rst), .din(din_a), .mode(mode), .sel(sel_a), .hold(hold),
    .dout(dout_c), .ch(ch_c), .valid(valid_c), .err(err_c));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  int scan_exp [18] = '{0,0,0,1,1, 1,1,1,1,1, 1,2,2,2,3,3,3,0};
  int sw_exp   [6]  = '{2,2,3,3,0,0};
  int rs_exp   [4]  = '{0,0,0,1};
  initial begin
    rst = 1'b1; hold = 1'b0; mode = 1'b0; sel_a = 2'd0; sel_b = 3'd0;
    din_a = $urandom; din_b = {$urandom, $urandom};
    step();
    din_a = $urandom;
    step();
    check("rst_dout", dout_a, 0);
    check("rst_ch", ch_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_err", err_a, 0);
    check("rst_b_ch", ch_b, 0);
    rst = 1'b0; sel_a = 2'd2; din_a = 32'h00A5_0000;
    step();
    check("first_dout", dout_a, 8'hA5);
    check("first_ch", ch_a, 2);
    check("first_valid", valid_a, 1);
    din_a = 32'h4433_2211;
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      step();
      check("sweep_dout", dout_a, 8'h11 * (s + 1));
      check("sweep_ch", ch_a, s);
    end
    din_b = 40'h55_4433_2211; sel_b = 3'd6;
    step();
    check("oor_err", err_b, 1);
    check("oor_valid", valid_b, 0);
    check("oor_dout", dout_b, 0);
    check("oor_ch", ch_b, 6);
    sel_b = 3'd4;
    step();
    check("top_err", err_b, 0);
    check("top_valid", valid_b, 1);
    check("top_dout", dout_b, 8'h55);
    sel_a = 2'd0;
    step();
    mode = 1'b1;
    for (int i = 0; i < 18; i++) begin
      hold  = (i >= 5 && i <= 9);
      din_a = hold ? 32'hDEAD_BEEF : 32'h4433_2211;
      step();
      check("scan_ch", ch_a, scan_exp[i]);
      check("scan_dout", dout_a, 8'h11 * (scan_exp[i] + 1));
      check("scan_valid", valid_a, 1);
    end
    hold = 1'b0; mode = 1'b0; sel_a = 2'd2;
    step();
    step();
    check("sw_man_ch", ch_c, 2);
    check("sw_man_dout", dout_c, 8'h33);
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("sw_scan_ch", ch_c, sw_exp[i]);
    end
    mode = 1'b0; sel_a = 2'd3;
    step();
    mode = 1'b1;
    step();
    check("mid_ch", ch_a, 3);
    rst = 1'b1; hold = 1'b1;
    step();
    check("mid_rst_dout", dout_a, 0);
    check("mid_rst_ch", ch_a, 0);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_err", err_a, 0);
    rst = 1'b0; hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_ch", ch_a, rs_exp[i]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
